// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between two
// writeback sources.
//   Source A (in-order pipeline) has fixed priority.
//   Source B (long-latency unit) gets a forced grant once it has been blocked
//   for STARVE_MAX consecutive cycles.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   a_valid/a_addr/a_data       source A request;  a_ready  combinational accept
//   b_valid/b_addr/b_data       source B request;  b_ready  combinational accept
//   rWriteAddress/rWriteValue   registered register-file write address/data
//   regWrite                    registered register-file write enable
//   force_cnt                   saturating count of forced B grants
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] rWriteAddress,
  output logic [DATA_W-1:0] rWriteValue,
  output logic              regWrite,
  output logic [15:0]       force_cnt
);

  localparam int unsigned FCNT_W = 16;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [FCNT_W-1:0]   force_cnt_q, force_cnt_d;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wen_q;
  logic                a_xfer;
  logic                b_xfer;

  // State, starvation counter and forced-grant counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRIO_A;
      wait_cnt_q  <= '0;
      force_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      force_cnt_q <= force_cnt_d;
    end
  end

  // Next-state, starvation tracking and ready generation
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    force_cnt_d = force_cnt_q;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    case (state_q)
      PRIO_A: begin
        a_ready = 1'b1;
        b_ready = !a_valid;
        if (b_valid && a_valid) begin
          // B blocked this cycle; the STARVE_MAX-th blocked cycle arms the force
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == CNT_W'(STARVE_MAX - 1)) begin
            state_d = FORCE_B;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      FORCE_B: begin
        b_ready = 1'b1;
        // A dropped b_valid is illegal; wait here until B re-presents
        if (b_valid) begin
          state_d    = PRIO_A;
          wait_cnt_d = '0;
          if (force_cnt_q != {FCNT_W{1'b1}}) begin
            force_cnt_d = force_cnt_q + FCNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = PRIO_A;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  // Register-file write stage; r0 writes are accepted but never enable the write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else if (a_xfer) begin
      waddr_q <= a_addr;
      wdata_q <= a_data;
      wen_q   <= (a_addr != '0);
    end else if (b_xfer) begin
      waddr_q <= b_addr;
      wdata_q <= b_data;
      wen_q   <= (b_addr != '0);
    end else begin
      wen_q   <= 1'b0;
    end
  end

  assign rWriteAddress = waddr_q;
  assign rWriteValue   = wdata_q;
  assign regWrite      = wen_q;
  assign force_cnt     = force_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned CNT_W      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [ADDR_W-1:0] rWriteAddress;
  logic [DATA_W-1:0] rWriteValue;
  logic              regWrite;
  logic [15:0]       force_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rWriteAddress(rWriteAddress), .rWriteValue(rWriteValue),
    .regWrite(regWrite), .force_cnt(force_cnt)
  );

  // Reference model: "forced" flag, consecutive blocked cycles, expected outputs
  bit                m_force;
  int                m_blocked;
  int                m_fc;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                m_ax, m_bx;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_force = 0; m_blocked = 0; m_fc = 0;
    m_we = 0; m_addr = '0; m_data = '0;
    m_ax = 0; m_bx = 0;
  endtask

  // Apply one rising edge worth of arbitration rules to the model
  task automatic model_edge();
    m_ax = a_valid && !m_force;
    m_bx = b_valid && (m_force || !a_valid);
    if (m_ax) begin
      m_we = (a_addr != 0); m_addr = a_addr; m_data = a_data;
    end else if (m_bx) begin
      m_we = (b_addr != 0); m_addr = b_addr; m_data = b_data;
    end else begin
      m_we = 0;
    end
    if (m_bx) begin
      m_blocked = 0;
      if (m_force) begin
        m_force = 0;
        if (m_fc < 65535) m_fc++;
      end
    end else if (!m_force) begin
      if (a_valid && b_valid) begin
        m_blocked++;
        if (m_blocked == int'(STARVE_MAX)) m_force = 1;
      end else begin
        m_blocked = 0;
      end
    end
  endtask

  // One clock: readies checked at negedge, registered outputs #1 after posedge
  task automatic cycle();
    @(negedge clk);
    check("a_ready", 32'(a_ready), 32'(!m_force));
    check("b_ready", 32'(b_ready), 32'(m_force || !a_valid));
    @(posedge clk);
    model_edge();
    #1;
    check("regWrite", 32'(regWrite), 32'(m_we));
    check("rWriteAddress", 32'(rWriteAddress), 32'(m_addr));
    check("rWriteValue", rWriteValue, m_data);
    check("force_cnt", 32'(force_cnt), 32'(m_fc));
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
    model_reset();

    // Reset values
    #12;
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_addr", 32'(rWriteAddress), 32'd0);
    check("rst_data", rWriteValue, 32'd0);
    check("rst_force_cnt", 32'(force_cnt), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // A only
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    check("aonly_we", 32'(regWrite), 32'd1);
    check("aonly_addr", 32'(rWriteAddress), 32'd5);
    check("aonly_data", rWriteValue, 32'hDEADBEEF);
    a_valid = 0;
    cycle();
    check("aonly_we_off", 32'(regWrite), 32'd0);

    // B only
    b_valid = 1; b_addr = 5'd9; b_data = 32'h1234;
    #1;
    check("bonly_ready", 32'(b_ready), 32'd1);
    cycle();
    check("bonly_we", 32'(regWrite), 32'd1);
    check("bonly_addr", 32'(rWriteAddress), 32'd9);
    check("bonly_data", rWriteValue, 32'h1234);
    b_valid = 0;

    // Starvation: A and B valid continuously
    a_valid = 1; a_addr = 5'd3; a_data = 32'hA0A0A0A0;
    b_valid = 1; b_addr = 5'd7; b_data = 32'hB0B0B0B0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i < 3) check("starve_blocked", 32'(b_ready), 32'd0);
    end
    check("starve_force_a", 32'(a_ready), 32'd0);
    check("starve_force_b", 32'(b_ready), 32'd1);
    cycle();
    check("starve_fc", 32'(force_cnt), 32'd1);
    check("starve_b_addr", 32'(rWriteAddress), 32'd7);
    check("starve_a_back", 32'(a_ready), 32'd1);
    b_valid = 0;
    cycle();
    check("starve_a_resume", 32'(rWriteAddress), 32'd3);

    // Reset asserted mid-FORCE_B
    b_valid = 1; b_addr = 5'd11; b_data = 32'h5555AAAA;
    for (int i = 0; i < 4; i++) cycle();
    check("pre_rst_forced", 32'(a_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_we", 32'(regWrite), 32'd0);
    check("midrst_fc", 32'(force_cnt), 32'd0);
    check("midrst_a_ready", 32'(a_ready), 32'd1);
    check("midrst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_we_edge", 32'(regWrite), 32'd0);
    rst = 1'b0;
    a_valid = 0; b_valid = 0;

    // r0 drop
    a_valid = 1; a_addr = '0; a_data = 32'hFFFFFFFF;
    cycle();
    check("r0_we", 32'(regWrite), 32'd0);

    // Back-to-back A for 20 cycles
    for (int i = 0; i < 20; i++) begin
      a_addr = ADDR_W'(i + 1); a_data = $urandom;
      cycle();
      check("b2b_we", 32'(regWrite), 32'd1);
    end
    check("b2b_fc", 32'(force_cnt), 32'd0);
    a_valid = 0;
    cycle();

    // Randomized traffic honoring the held-valid rule
    m_ax = 0; m_bx = 0;
    for (int i = 0; i < 600; i++) begin
      if (!a_valid || m_ax) begin
        a_valid = ($urandom_range(0, 99) < 65);
        a_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
        a_data  = $urandom;
      end
      if (!b_valid || m_bx) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
        b_data  = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
